// File: rtl/delta_sigma_decimator.sv
// ============================================================================
// Module      : delta_sigma_decimator
// Description : Third-order CIC (sinc^3) decimator for a 4-bit signed
//               delta-sigma modulator stream, with start-up suppression.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delta_sigma_decimator #(
    parameter int DECIM = 16,
    parameter int OUT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       data_in,
    output logic [OUT_W-1:0] data_out,
    output logic             out_valid
);

    localparam int c_LOG2  = $clog2(DECIM);
    localparam int c_W     = 4 + 3 * c_LOG2;
    localparam int c_CNT_W = c_LOG2;
    localparam logic [c_CNT_W-1:0] c_LAST_PHASE = c_CNT_W'(DECIM - 1);

    logic [c_CNT_W-1:0] r_phase;
    logic [c_W-1:0]     r_int1;
    logic [c_W-1:0]     r_int2;
    logic [c_W-1:0]     r_int3;
    logic [c_W-1:0]     r_dec;
    logic               r_dec_valid;
    logic [c_W-1:0]     r_d1;
    logic [c_W-1:0]     r_d2;
    logic [c_W-1:0]     r_d3;
    logic [1:0]         r_warm;

    logic [c_W-1:0]     w_in_ext;
    logic [c_W-1:0]     w_int3_next;
    logic               w_last;
    logic [c_W-1:0]     w_c1;
    logic [c_W-1:0]     w_c2;
    logic [c_W-1:0]     w_c3;
    logic [OUT_W-1:0]   w_scaled;

    assign w_in_ext    = {{(c_W-4){data_in[3]}}, data_in};
    assign w_int3_next = r_int3 + r_int2;
    assign w_last      = (r_phase == c_LAST_PHASE);

    // Integrators run at the input rate; modulo-2^W wrap cancels in the combs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase     <= '0;
            r_int1      <= '0;
            r_int2      <= '0;
            r_int3      <= '0;
            r_dec       <= '0;
            r_dec_valid <= 1'b0;
        end else begin
            r_dec_valid <= 1'b0;
            if (in_valid) begin
                r_int1  <= r_int1 + w_in_ext;
                r_int2  <= r_int2 + r_int1;
                r_int3  <= w_int3_next;
                r_phase <= w_last ? '0 : r_phase + 1'b1;
                if (w_last) begin
                    r_dec       <= w_int3_next;
                    r_dec_valid <= 1'b1;
                end
            end
        end
    end

    assign w_c1 = r_dec - r_d1;
    assign w_c2 = w_c1 - r_d2;
    assign w_c3 = w_c2 - r_d3;

    generate
        if (c_W >= OUT_W) begin : g_trunc
            assign w_scaled = OUT_W'(w_c3 >> (c_W - OUT_W));
        end else begin : g_extend
            assign w_scaled = OUT_W'(w_c3) << (OUT_W - c_W);
        end
    endgenerate

    // The first two decimated results only prime the comb delay line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_warm    <= 2'd0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (r_dec_valid) begin
                r_d1 <= r_dec;
                r_d2 <= w_c1;
                r_d3 <= w_c2;
                if (r_warm == 2'd2) begin
                    data_out  <= w_scaled;
                    out_valid <= 1'b1;
                end else begin
                    r_warm <= r_warm + 2'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_delta_sigma_decimator.sv
// ============================================================================
// Module      : tb_delta_sigma_decimator
// Description : Self-checking bench for delta_sigma_decimator (DECIM=16,
//               OUT_W=14) using a direct sinc^3 convolution reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delta_sigma_decimator;

    localparam int DECIM = 16;
    localparam int OUT_W = 14;
    localparam int W_INT = 4 + 3 * $clog2(DECIM);
    localparam int SHIFT = W_INT - OUT_W;
    localparam int NTAP  = 3 * DECIM;

    localparam logic [13:0] E_DC1 = 14'd1024;
    localparam logic [13:0] E_P7  = 14'd7168;
    localparam logic [13:0] E_N8  = 14'h2000;
    localparam logic [13:0] E_ALT = 14'h3E00;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [3:0]       data_in;
    logic [OUT_W-1:0] data_out;
    logic             out_valid;

    delta_sigma_decimator #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int coef [NTAP];
    int hist [$];
    int n_acc, n_grp, cyc;
    logic        pend;
    logic [13:0] pend_val;
    logic [13:0] exp_dout;
    int          n_pulses, last_pulse, gap;
    logic [13:0] last_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Impulse response of (1 + z^-1 + ... + z^-(D-1))^3 by repeated convolution.
    task automatic build_coef();
        int a [NTAP];
        int b [NTAP];
        for (int i = 0; i < NTAP; i++) begin
            a[i] = (i < DECIM) ? 1 : 0;
            b[i] = 0;
        end
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NTAP; i++) begin
                b[i] = 0;
                for (int k = 0; k < DECIM; k++)
                    if (i - k >= 0) b[i] += a[i - k];
            end
            a = b;
        end
        coef = a;
    endtask

    // Decimated output after n accepted samples: the two newest samples have
    // not yet reached integrator 3, so the response starts two samples back.
    function automatic logic [13:0] model_out();
        int y = 0;
        for (int t = 2; t < NTAP; t++)
            y += coef[t - 2] * hist[NTAP - 1 - t];
        y = y >>> SHIFT;
        return y[13:0];
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < NTAP; i++) hist.push_back(0);
        n_acc    = 0;
        n_grp    = 0;
        pend     = 1'b0;
        exp_dout = '0;
        n_pulses = 0;
        last_pulse = 0;
        gap      = 0;
        last_val = '0;
    endtask

    task automatic step(input logic v, input logic [3:0] d);
        logic ev;
        ev = pend;
        if (pend) exp_dout = pend_val;
        pend = 1'b0;
        in_valid = v;
        data_in  = d;
        @(posedge clk);
        #1;
        cyc++;
        if (v) begin
            hist.push_back(int'($signed(d)));
            void'(hist.pop_front());
            n_acc++;
            if (n_acc % DECIM == 0) begin
                n_grp++;
                if (n_grp >= 3) begin
                    pend     = 1'b1;
                    pend_val = model_out();
                end
            end
        end
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("data_out", {18'd0, data_out}, {18'd0, exp_dout});
        if (out_valid) begin
            gap        = cyc - last_pulse;
            last_pulse = cyc;
            last_val   = data_out;
            n_pulses++;
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        #1;
        chk("rst_async_dout", {18'd0, data_out}, 32'd0);
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < cycles; i++) begin
            in_valid = 1'b1;
            data_in  = 4'd7;
            @(posedge clk);
            #1;
            cyc++;
            chk("rst_hold_dout", {18'd0, data_out}, 32'd0);
            chk("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        end
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = 4'd0;
        cyc      = 0;
        build_coef();
        model_reset();
        #2;

        // Long reset with active input
        do_reset(50);

        // DC = 1, valid every cycle
        for (int i = 0; i < 48; i++) step(1'b1, 4'd1);
        chk("dc1_no_early_pulse", n_pulses, 0);
        step(1'b1, 4'd1);
        chk("dc1_first_pulse", n_pulses, 1);
        chk("dc1_first_val", {18'd0, last_val}, {18'd0, E_DC1});
        for (int i = 0; i < 32; i++) step(1'b1, 4'd1);
        chk("dc1_gap", gap, 16);
        chk("dc1_val", {18'd0, last_val}, {18'd0, E_DC1});

        // DC = 1, valid every other cycle
        do_reset(3);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 4'd1);
            step(1'b0, 4'($urandom));
        end
        chk("dc1_sparse_val", {18'd0, last_val}, {18'd0, E_DC1});
        chk("dc1_sparse_gap", gap, 32);

        // Reset mid-group discards the partial group
        do_reset(2);
        for (int i = 0; i < 40; i++) step(1'b1, 4'd1);
        do_reset(2);
        for (int i = 0; i < 48; i++) step(1'b1, 4'd1);
        chk("midrst_no_pulse", n_pulses, 0);
        step(1'b0, 4'd1);
        chk("midrst_pulse", n_pulses, 1);
        chk("midrst_val", {18'd0, last_val}, {18'd0, E_DC1});

        // Full-scale DC through integrator wrap
        for (int i = 0; i < 10000; i++) step(1'b1, 4'd7);
        chk("dc_p7", {18'd0, last_val}, {18'd0, E_P7});
        for (int i = 0; i < 10000; i++) step(1'b1, 4'h8);
        chk("dc_n8", {18'd0, last_val}, {18'd0, E_N8});

        // Alternating extremes
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 4'd7);
            step(1'b1, 4'h8);
        end
        chk("alt_val", {18'd0, last_val}, {18'd0, E_ALT});

        // Random data with random valid gaps and one reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(2);
            step(($urandom_range(0, 9) < 7), 4'($urandom));
        end
        chk("rand_pulses_seen", {31'd0, (n_pulses > 0)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
